// File: rtl/trim_pwm_pkg.sv
// Shared types and constants for the TrimPWM dead-band inserter.
package trim_pwm_pkg;

    typedef enum logic [2:0] {
        SAFE,
        LOW,
        DB_RISE,
        HIGH,
        DB_FALL
    } db_state_e;

    localparam int TRIM_PWM_SYNC_STAGES = 2;

endpackage

// File: rtl/trim_pwm_db_counter.sv
// Dead-band down-counter: load with the effective dead time, decrement
// while waiting, expire flags the last dead cycle.
module trim_pwm_db_counter #(
    parameter int DeadTimeBits = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load,
    input  logic                    dec,
    input  logic [DeadTimeBits-1:0] load_val,
    output logic                    expire
);

    logic [DeadTimeBits-1:0] cnt_q;
    logic [DeadTimeBits-1:0] cnt_d;

    assign expire = (cnt_q == DeadTimeBits'(1));

    // Never decrement past 1, so a full-scale load cannot wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && !expire && (cnt_q != '0)) begin
            cnt_d = cnt_q - DeadTimeBits'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/trim_pwm_deadband.sv
// Complementary half-bridge drive with programmable dead band and a
// sticky, synchronised kill path that forces both phases off.
module trim_pwm_deadband
    import trim_pwm_pkg::*;
#(
    parameter int DeadTimeBits = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    pwm_in,
    input  logic [DeadTimeBits-1:0] dead_time,
    input  logic                    kill,
    input  logic                    fault_clr,
    output logic                    ph_hi,
    output logic                    ph_lo,
    output logic                    fault
);

    db_state_e state_q;
    db_state_e state_d;
    logic [TRIM_PWM_SYNC_STAGES-1:0] kill_sync_q;
    logic [TRIM_PWM_SYNC_STAGES-1:0] kill_sync_d;
    logic kill_s;
    logic fault_q;
    logic fault_d;
    logic ph_hi_q;
    logic ph_hi_d;
    logic ph_lo_q;
    logic ph_lo_d;
    logic cnt_load;
    logic cnt_dec;
    logic cnt_expire;
    logic [DeadTimeBits-1:0] eff_dead;

    assign kill_sync_d = {kill_sync_q[TRIM_PWM_SYNC_STAGES-2:0], kill};
    assign kill_s      = kill_sync_q[TRIM_PWM_SYNC_STAGES-1];
    assign eff_dead    = (dead_time == '0) ? DeadTimeBits'(1) : dead_time;

    trim_pwm_db_counter #(
        .DeadTimeBits(DeadTimeBits)
    ) u_db_counter (
        .clock   (clock),
        .reset   (reset),
        .load    (cnt_load),
        .dec     (cnt_dec),
        .load_val(eff_dead),
        .expire  (cnt_expire)
    );

    always_comb begin
        state_d  = state_q;
        fault_d  = fault_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;

        // Set beats clear when both arrive together.
        if (kill_s) begin
            fault_d = 1'b1;
        end else if (fault_clr) begin
            fault_d = 1'b0;
        end

        if (!en || kill_s) begin
            state_d = SAFE;
        end else begin
            unique case (state_q)
                SAFE: begin
                    if (!fault_q) begin
                        state_d  = pwm_in ? DB_RISE : DB_FALL;
                        cnt_load = 1'b1;
                    end
                end
                LOW: begin
                    if (pwm_in) begin
                        state_d  = DB_RISE;
                        cnt_load = 1'b1;
                    end
                end
                HIGH: begin
                    if (!pwm_in) begin
                        state_d  = DB_FALL;
                        cnt_load = 1'b1;
                    end
                end
                DB_RISE: begin
                    if (!pwm_in) begin
                        state_d = LOW;
                    end else if (cnt_expire) begin
                        state_d = HIGH;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                DB_FALL: begin
                    if (pwm_in) begin
                        state_d = HIGH;
                    end else if (cnt_expire) begin
                        state_d = LOW;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                default: state_d = SAFE;
            endcase
        end

        ph_hi_d = (state_d == HIGH);
        ph_lo_d = (state_d == LOW);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= SAFE;
            kill_sync_q <= '0;
            fault_q     <= 1'b0;
            ph_hi_q     <= 1'b0;
            ph_lo_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            kill_sync_q <= kill_sync_d;
            fault_q     <= fault_d;
            ph_hi_q     <= ph_hi_d;
            ph_lo_q     <= ph_lo_d;
        end
    end

    assign ph_hi = ph_hi_q;
    assign ph_lo = ph_lo_q;
    assign fault = fault_q;

endmodule
